// File: rtl/nibble_serial_addsub_pkg.sv
`default_nettype none
// ============================================================================
// Module      : nibble_serial_addsub_pkg
// Description : Shared types and constants for the nibble-serial add/sub
//               block: controller state type and the slice width.
// Revision    : 1.0 - initial release
// ============================================================================
package nibble_serial_addsub_pkg;

    // Width of one arithmetic slice; operands are processed this many bits
    // per clock.
    localparam int c_slice_w = 4;

    // Controller states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage : nibble_serial_addsub_pkg
`default_nettype wire

// File: rtl/bit_adder_subtractor.sv
`default_nettype none
// ============================================================================
// Module      : bit_adder_subtractor
// Description : 4-bit ripple-carry slice. Subtraction is obtained by the
//               caller feeding an inverted B operand and a carry-in of 1.
// Revision    : 1.0 - initial release
// ============================================================================
module bit_adder_subtractor (
    output logic [3:0] sum,
    output logic       cout,
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin
);

    logic [4:0] w_c;

    assign w_c[0] = cin;

    // One full adder per bit, carry rippling upward.
    for (genvar i = 0; i < 4; i++) begin : g_bit
        assign sum[i]   = a[i] ^ b[i] ^ w_c[i];
        assign w_c[i+1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
    end

    assign cout = w_c[4];

endmodule : bit_adder_subtractor
`default_nettype wire

// File: rtl/nibble_serial_addsub.sv
`default_nettype none
// ============================================================================
// Module      : nibble_serial_addsub
// Description : Serial adder/subtractor that processes one 4-bit nibble per
//               clock, least significant first, with a valid/ready request
//               port and a valid/ready result port.
// Revision    : 1.0 - initial release
// ============================================================================
module nibble_serial_addsub
    import nibble_serial_addsub_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [4*NIBBLES-1:0] a,
    input  logic [4*NIBBLES-1:0] b,
    input  logic                 sub,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [4*NIBBLES-1:0] result,
    output logic                 cout,
    output logic                 ovf,
    output logic                 zero
);

    localparam int c_w     = c_slice_w * NIBBLES;
    localparam int c_cnt_w = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    state_t               r_state;
    state_t               w_state_nxt;

    // Captured operands; B is stored already conditionally inverted so the
    // slice only ever adds.
    logic [c_w-1:0]       r_a;
    logic [c_w-1:0]       r_b;
    logic [c_w-1:0]       r_result;
    logic                 r_carry;
    logic                 r_cout;
    logic                 r_ovf;
    logic [c_cnt_w-1:0]   r_cnt;

    logic [c_slice_w-1:0] w_nib_a;
    logic [c_slice_w-1:0] w_nib_b;
    logic [c_slice_w-1:0] w_sum;
    logic                 w_c;
    logic                 w_last;
    logic                 w_ovf;

    assign w_nib_a = r_a[r_cnt*c_slice_w +: c_slice_w];
    assign w_nib_b = r_b[r_cnt*c_slice_w +: c_slice_w];
    assign w_last  = (r_cnt == c_cnt_w'(NIBBLES - 1));

    // On the last nibble the slice sees the operand sign bits, so overflow
    // can be judged from the slice inputs and its sum directly.
    assign w_ovf = (w_nib_a[c_slice_w-1] == w_nib_b[c_slice_w-1]) &&
                   (w_sum[c_slice_w-1]   != w_nib_a[c_slice_w-1]);

    bit_adder_subtractor u_slice (
        .sum  (w_sum),
        .cout (w_c),
        .a    (w_nib_a),
        .b    (w_nib_b),
        .cin  (r_carry)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_last) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Operand capture, per-nibble accumulation and final flag registration.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a      <= '0;
            r_b      <= '0;
            r_result <= '0;
            r_carry  <= 1'b0;
            r_cout   <= 1'b0;
            r_ovf    <= 1'b0;
            r_cnt    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_a     <= a;
                        r_b     <= b ^ {c_w{sub}};
                        r_carry <= sub;
                        r_cnt   <= '0;
                        r_cout  <= 1'b0;
                        r_ovf   <= 1'b0;
                    end
                end
                ST_RUN: begin
                    r_result[r_cnt*c_slice_w +: c_slice_w] <= w_sum;
                    r_carry <= w_c;
                    r_cnt   <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_cout <= w_c;
                        r_ovf  <= w_ovf;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign result = r_result;
    assign cout   = r_cout;
    assign ovf    = r_ovf;
    assign zero   = out_valid && (r_result == '0);

endmodule : nibble_serial_addsub
`default_nettype wire

// File: tb/tb_nibble_serial_addsub.sv
`default_nettype none
// ============================================================================
// Module      : tb_nibble_serial_addsub
// Description : Directed-vector bench for nibble_serial_addsub with a
//               scoreboard queue and an independent result monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nibble_serial_addsub;

    localparam int NIBBLES = 4;
    localparam int W       = 4 * NIBBLES;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         cout;
    logic         ovf;
    logic         zero;

    typedef struct packed {
        logic [W-1:0] r;
        logic         c;
        logic         o;
        logic         z;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    nibble_serial_addsub #(.NIBBLES(NIBBLES)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .cout      (cout),
        .ovf       (ovf),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: compares every presented result at the moment it is consumed.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_result: got 0x%0h, expected no result", result);
            end else begin
                e = sb_q.pop_front();
                check("sb_result", result, e.r);
                check("sb_cout", W'(cout), W'(e.c));
                check("sb_ovf", W'(ovf), W'(e.o));
                check("sb_zero", W'(zero), W'(e.z));
            end
        end
    end

    // One full transaction; entered and left at 1 time unit after a rising edge.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic ts,
                          input logic [W-1:0] er, input logic ec, input logic eo,
                          input logic ez, input int hold);
        check("in_ready_idle", W'(in_ready), W'(1'b1));
        a        = ta;
        b        = tb_v;
        sub      = ts;
        in_valid = 1'b1;
        sb_q.push_back(exp_t'{r: er, c: ec, o: eo, z: ez});
        @(posedge clk);
        #1;
        // Scramble inputs: the captured operation must be unaffected.
        in_valid = 1'b0;
        a        = ~ta;
        b        = ta ^ tb_v;
        sub      = ~ts;
        for (int k = 1; k <= NIBBLES; k++) begin
            @(posedge clk);
            #1;
            check("out_valid_latency", W'(out_valid), W'(k == NIBBLES));
        end
        for (int h = 0; h < hold; h++) begin
            check("hold_result", result, er);
            check("hold_ovf", W'(ovf), W'(eo));
            check("hold_in_ready", W'(in_ready), W'(1'b0));
            in_valid = 1'b1;
            a        = W'(h + 3);
            b        = W'(h * 7);
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        check("pre_handshake_valid", W'(out_valid), W'(1'b1));
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("post_handshake_valid", W'(out_valid), W'(1'b0));
        check("post_handshake_in_ready", W'(in_ready), W'(1'b1));
    endtask

    // Watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // Stimulus.
    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        sub       = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_in_ready", W'(in_ready), W'(1'b1));
        check("rst_out_valid", W'(out_valid), W'(1'b0));
        check("rst_result", result, 16'h0000);
        check("rst_cout", W'(cout), W'(1'b0));
        check("rst_ovf", W'(ovf), W'(1'b0));
        check("rst_zero", W'(zero), W'(1'b0));

        // out_ready in IDLE is ignored.
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("idle_out_ready_ignored", W'(out_valid), W'(1'b0));

        run_op(16'h1234, 16'h0FCD, 1'b0, 16'h2201, 1'b0, 1'b0, 1'b0, 0);
        run_op(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 0);
        run_op(16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0, 0);
        run_op(16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0, 1);
        run_op(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0, 3);
        run_op(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 0);
        run_op(16'h1234, 16'h1234, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1, 2);

        // Abort an operation with reset during its second RUN cycle.
        a        = 16'h1111;
        b        = 16'h2222;
        sub      = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst       = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        rst       = 1'b0;
        out_ready = 1'b0;
        check("abort_out_valid", W'(out_valid), W'(1'b0));
        check("abort_in_ready", W'(in_ready), W'(1'b1));
        check("abort_result", result, 16'h0000);
        check("abort_cout", W'(cout), W'(1'b0));
        check("abort_ovf", W'(ovf), W'(1'b0));
        check("abort_zero", W'(zero), W'(1'b0));
        repeat (NIBBLES + 1) @(posedge clk);
        #1;
        check("abort_stays_idle", W'(out_valid), W'(1'b0));

        run_op(16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0, 0);

        repeat (2) @(posedge clk);
        #1;
        check("scoreboard_drained", W'(sb_q.size()), 16'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_nibble_serial_addsub
`default_nettype wire

// File: doc/nibble_serial_addsub.md
NIBBLE_SERIAL_ADDSUB -- requirements
Module: nibble_serial_addsub

Interface
REQ-001 Parameter: NIBBLES, 4, number of 4-bit slices per operand; operand width W = 4*NIBBLES.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 in_valid  input  1  operand request valid.
REQ-005 in_ready  output  1  block can accept a request.
REQ-006 a  input  W  operand A.
REQ-007 b  input  W  operand B.
REQ-008 sub  input  1  0 = A+B, 1 = A-B (two's complement).
REQ-009 out_valid  output  1  result valid.
REQ-010 out_ready  input  1  consumer accepts result.
REQ-011 result  output  W  sum or difference, modulo 2^W.
REQ-012 cout  output  1  final carry; for subtraction 1 = no borrow (A >= B unsigned).
REQ-013 ovf  output  1  signed two's-complement overflow.
REQ-014 zero  output  1  result == 0.

Function
REQ-015 States: IDLE, RUN, DONE; encoding internal.
REQ-016 IDLE: in_ready=1, out_valid=0; in_valid&&in_ready at an edge captures a, b, sub, loads carry register with sub, nibble counter with 0, and moves to RUN.
REQ-017 in_ready SHALL be 0 in RUN and DONE; in_valid in those states is ignored, with no effect on state or outputs.
REQ-018 Input changes after the accepting edge SHALL NOT affect the operation in progress.
REQ-019 RUN, counter k: adds nibble k of A, nibble k of (B XOR {W{sub}}), and the carry register; writes the 4-bit sum into result nibble k and its carry-out into the carry register at the edge; k increments.
REQ-020 RUN exits to DONE at the edge processing nibble NIBBLES-1; out_valid rises exactly NIBBLES edges after the accepting edge.
REQ-021 DONE: out_valid=1; result, cout, ovf, zero stable until handshake.
REQ-022 cout = carry register after the last nibble.
REQ-023 ovf = (A[W-1] == B'[W-1]) && (result[W-1] != A[W-1]), where B' = B XOR {W{sub}}.
REQ-024 zero = (result == 0), derived from the registered result.
REQ-025 DONE with out_valid&&out_ready at an edge moves to IDLE; in_ready rises the cycle after; no same-cycle re-accept.
REQ-026 out_ready low in DONE holds state and all outputs indefinitely.
REQ-027 out_ready in IDLE or RUN is ignored.
REQ-028 Arithmetic wraps modulo 2^W; no saturation.

Reset
REQ-029 rst high at an edge forces IDLE, counter=0, carry register=0, result=0, cout=0, ovf=0, zero=0, out_valid=0; in_ready=1 from the next cycle.
REQ-030 rst SHALL take priority over every handshake; rst in RUN or DONE aborts the operation and discards the result.

Structure
REQ-031 Shared package holds the state type and the slice width constant (4); NIBBLES remains a module parameter.
REQ-032 The per-nibble add SHALL be one instance of the existing 4-bit ripple slice bit_adder_subtractor (sum, cout, a, b, cin); the block supplies the pre-inverted B nibble and the carry.
REQ-033 Counter width is clog2(NIBBLES), minimum 1.

Verification
REQ-034 a=0x1234, b=0x0FCD, sub=0 -> after 4 edges result=0x2201, cout=0, ovf=0, zero=0.
REQ-035 a=0xFFFF, b=0x0001, sub=0 -> result=0x0000, cout=1, ovf=0, zero=1.
REQ-036 a=0x0005, b=0x0007, sub=1 -> result=0xFFFE, cout=0, ovf=0; a=0x8000, b=0x0001, sub=1 -> result=0x7FFF, cout=1, ovf=1.
REQ-037 a=0x7FFF, b=0x0001, sub=0 with out_ready low 3 cycles in DONE -> result=0x8000, ovf=1 held stable for 3 cycles; in_ready=0 and a second in_valid is ignored; in_ready=1 the cycle after the out handshake.
REQ-038 Request accepted, rst asserted during the 2nd RUN cycle -> next cycle IDLE, out_valid=0, result=0; a fresh request 0x0001+0x0001 then yields 0x0002.
